// File: rtl/dbg_slave_pkg.sv
// Shared types and defaults for the system-clock debug slave: channel FSM
// states, default parameter values and the action-bit locator.
package dbg_slave_pkg;

    typedef enum logic {
        CH_IDLE    = 1'b0,
        CH_PENDING = 1'b1
    } ch_state_e;

    localparam int IR_W_DEF        = 2;
    localparam int DR_W_DEF        = 38;
    localparam int NUM_CH_DEF      = 4;
    localparam int SYNC_STAGES_DEF = 3;

    // The command's action flag is the top bit of the captured data word.
    function automatic int action_bit_idx(input int dr_w);
        return dr_w - 1;
    endfunction

endpackage

// File: rtl/dbg_sync_edge.sv
// Level synchronizer followed by a rising-edge detector. A level that is
// already high when reset releases must fall before it can produce a rise.
module dbg_sync_edge #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   edge_q;
    logic                   armed_q;

    // fill_q marks when sync_q holds real samples; arming waits for a low one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            edge_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            edge_q  <= sync_q[SYNC_STAGES-1];
            armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
        end
    end

    assign rise_o = armed_q & sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/dbg_slave_sysclk_mc.sv
// Debug slave, system-clock side: turns TCK-domain update strobes into
// per-channel action pulses with pending tracking and sticky errors.
// Optional feature macro: DBG_SLAVE_OVR_CNT_EN (saturating overrun counter).
module dbg_slave_sysclk_mc
    import dbg_slave_pkg::*;
#(
    parameter int IR_W        = IR_W_DEF,
    parameter int DR_W        = DR_W_DEF,
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DR_W-1:0]   sr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              vs_udr,
    input  logic              vs_uir,
    input  logic [NUM_CH-1:0] ch_ack,
    input  logic              clr_err,
    output logic [DR_W-1:0]   jdo,
    output logic [NUM_CH-1:0] take_action,
    output logic [NUM_CH-1:0] take_no_action,
    output logic [NUM_CH-1:0] ch_pending,
    output logic              overrun,
    output logic              bad_ir,
    output logic [7:0]        overrun_cnt
);

    localparam int              ACT_BIT  = action_bit_idx(DR_W);
    localparam logic [IR_W:0]   NUM_CH_W = (IR_W+1)'(NUM_CH);

    logic udr_rise;
    logic uir_rise;

    dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (vs_udr),
        .rise_o  (udr_rise)
    );

    dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (vs_uir),
        .rise_o  (uir_rise)
    );

    logic [IR_W-1:0]   ir_q, ir_d;
    logic [DR_W-1:0]   jdo_q, jdo_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [IR_W-1:0]   cmd_ch_q, cmd_ch_d;
    logic [NUM_CH-1:0] take_action_q, take_action_d;
    logic [NUM_CH-1:0] take_no_action_q, take_no_action_d;
    logic              overrun_q, overrun_d;
    logic              bad_ir_q, bad_ir_d;
    logic              cmd_mapped;
    logic              bad_evt;
    logic              ovr_evt;
    logic [NUM_CH-1:0] pulse;

    // An update-IR in the same cycle as update-DR steers that command.
    always_comb begin
        ir_d        = uir_rise ? ir_in : ir_q;
        cmd_mapped  = ({1'b0, ir_d} < NUM_CH_W);
        jdo_d       = udr_rise ? sr : jdo_q;
        cmd_valid_d = udr_rise & cmd_mapped;
        cmd_ch_d    = udr_rise ? ir_d : cmd_ch_q;
        bad_evt     = udr_rise & ~cmd_mapped;
    end

    always_comb begin
        take_action_d    = '0;
        take_no_action_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_valid_q && (cmd_ch_q == IR_W'(i))) begin
                take_action_d[i]    = jdo_q[ACT_BIT];
                take_no_action_d[i] = ~jdo_q[ACT_BIT];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q             <= '0;
            jdo_q            <= '0;
            cmd_valid_q      <= 1'b0;
            cmd_ch_q         <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overrun_q        <= 1'b0;
            bad_ir_q         <= 1'b0;
        end else begin
            ir_q             <= ir_d;
            jdo_q            <= jdo_d;
            cmd_valid_q      <= cmd_valid_d;
            cmd_ch_q         <= cmd_ch_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            overrun_q        <= overrun_d;
            bad_ir_q         <= bad_ir_d;
        end
    end

    // Channel handshake: a pulse opens a command (PENDING); ch_ack[i] closes
    // it. Ack on an idle channel is ignored; ack coinciding with a new pulse
    // closes the old command and opens the new one, so PENDING holds.
    ch_state_e state_q [NUM_CH];
    ch_state_e state_d [NUM_CH];

    assign pulse = take_action_q | take_no_action_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= CH_IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                CH_IDLE:    if (pulse[i]) state_d[i] = CH_PENDING;
                CH_PENDING: if (ch_ack[i] && !pulse[i]) state_d[i] = CH_IDLE;
                default:    state_d[i] = CH_IDLE;
            endcase
        end
    end

    always_comb begin
        ch_pending = '0;
        ovr_evt    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_pending[i] = (state_q[i] == CH_PENDING);
            if (pulse[i] && (state_q[i] == CH_PENDING) && !ch_ack[i]) ovr_evt = 1'b1;
        end
    end

    // A set event in the clearing cycle wins.
    always_comb begin
        overrun_d = ovr_evt | (overrun_q & ~clr_err);
        bad_ir_d  = bad_evt | (bad_ir_q & ~clr_err);
    end

`ifdef DBG_SLAVE_OVR_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = clr_err ? 8'd0 : ovr_cnt_q;
        if (ovr_evt && (ovr_cnt_d != 8'hFF)) ovr_cnt_d = ovr_cnt_d + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ovr_cnt_q <= 8'd0;
        else          ovr_cnt_q <= ovr_cnt_d;
    end

    assign overrun_cnt = ovr_cnt_q;
`else
    assign overrun_cnt = 8'd0;
`endif

    assign jdo            = jdo_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign overrun        = overrun_q;
    assign bad_ir         = bad_ir_q;

endmodule

// File: tb/tb_dbg_slave_sysclk_mc.sv
// Bench for dbg_slave_sysclk_mc: a 4-channel and a 3-channel instance share
// stimulus; a command-level model predicts pulses, pending and error flags.
module tb_dbg_slave_sysclk_mc;

  localparam int IR_W = 2;
  localparam int DR_W = 38;
  localparam int S    = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [DR_W-1:0] sr = '0;
  logic [IR_W-1:0] ir_in = '0;
  logic            vs_udr = 1'b0;
  logic            vs_uir = 1'b0;
  logic [3:0]      ch_ack = '0;
  logic            clr_err = 1'b0;

  logic [DR_W-1:0] jdo_a, jdo_b;
  logic [3:0]      ta_a, tn_a, pend_a;
  logic [2:0]      ta_b, tn_b, pend_b;
  logic            ovr_a, ovr_b, bad_a, bad_b;
  logic [7:0]      cnt_a, cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  // model state, index 0 = 4-channel instance, 1 = 3-channel instance
  int              nch [2] = '{4, 3};
  logic [3:0]      exp_pend [2];
  logic            exp_ovr [2];
  logic            exp_bad [2];
  int              exp_cnt [2];
  logic [DR_W-1:0] exp_jdo;
  logic [IR_W-1:0] cur_ir;

  dbg_slave_sysclk_mc #(.IR_W(IR_W), .DR_W(DR_W), .NUM_CH(4), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ch_ack(ch_ack), .clr_err(clr_err), .jdo(jdo_a), .take_action(ta_a),
    .take_no_action(tn_a), .ch_pending(pend_a), .overrun(ovr_a), .bad_ir(bad_a),
    .overrun_cnt(cnt_a)
  );

  dbg_slave_sysclk_mc #(.IR_W(IR_W), .DR_W(DR_W), .NUM_CH(3), .SYNC_STAGES(S)) dut3 (
    .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ch_ack(ch_ack[2:0]), .clr_err(clr_err), .jdo(jdo_b), .take_action(ta_b),
    .take_no_action(tn_b), .ch_pending(pend_b), .overrun(ovr_b), .bad_ir(bad_b),
    .overrun_cnt(cnt_b)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_pend[d] = '0;
      exp_ovr[d]  = 1'b0;
      exp_bad[d]  = 1'b0;
      exp_cnt[d]  = 0;
    end
    exp_jdo = '0;
    cur_ir  = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_zero_a"}, 64'({jdo_a, ta_a, tn_a, pend_a, ovr_a, bad_a, cnt_a}), 64'd0);
    chk({tag, "_zero_b"}, 64'({jdo_b, ta_b, tn_b, pend_b, ovr_b, bad_b, cnt_b}), 64'd0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pend_a"}, 64'(pend_a), 64'(exp_pend[0]));
    chk({tag, "_pend_b"}, 64'(pend_b), 64'(exp_pend[1][2:0]));
    chk({tag, "_ovr_a"},  64'(ovr_a),  64'(exp_ovr[0]));
    chk({tag, "_ovr_b"},  64'(ovr_b),  64'(exp_ovr[1]));
    chk({tag, "_bad_a"},  64'(bad_a),  64'(exp_bad[0]));
    chk({tag, "_bad_b"},  64'(bad_b),  64'(exp_bad[1]));
    chk({tag, "_cnt_a"},  64'(cnt_a),  64'(exp_cnt[0]));
    chk({tag, "_cnt_b"},  64'(cnt_b),  64'(exp_cnt[1]));
    chk({tag, "_jdo_a"},  64'(jdo_a),  64'(exp_jdo));
    chk({tag, "_jdo_b"},  64'(jdo_b),  64'(exp_jdo));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (S + 4) @(negedge clk);
  endtask

  task automatic set_ir(input logic [IR_W-1:0] v);
    ir_in  = v;
    vs_uir = 1'b1;
    repeat (S + 3) @(negedge clk);
    vs_uir = 1'b0;
    repeat (S + 2) @(negedge clk);
    cur_ir = v;
  endtask

  // One update-DR command; optionally a simultaneous update-IR, and
  // optionally an ack of the same channel in the pulse cycle.
  task automatic send(input string tag, input logic [DR_W-1:0] data, input logic with_ir,
                      input logic [IR_W-1:0] new_ir, input logic ack_pulse);
    logic [15:0] exp_q[$];
    logic [15:0] w;
    logic [3:0]  oh;
    logic        act;
    @(negedge clk);
    if (with_ir) begin
      ir_in  = new_ir;
      vs_uir = 1'b1;
      cur_ir = new_ir;
    end
    sr     = data;
    vs_udr = 1'b1;
    oh     = 4'b0001 << cur_ir;
    act    = data[DR_W-1];
    for (int k = 1; k <= S + 3; k++) begin
      w = '0;
      if (k == S + 2) begin
        if (act) w[15:12] = oh; else w[11:8] = oh;
        if (int'(cur_ir) < 3) begin
          if (act) w[7:5] = oh[2:0]; else w[4:2] = oh[2:0];
        end
      end
      exp_q.push_back(w);
    end
    for (int k = 1; k <= S + 3; k++) begin
      @(negedge clk);
      w = exp_q.pop_front();
      chk({tag, "_pulse_a"}, 64'({ta_a, tn_a}), 64'(w[15:8]));
      chk({tag, "_pulse_b"}, 64'({ta_b, tn_b}), 64'(w[7:2]));
      if (k >= S + 1) begin
        chk({tag, "_jdo_early_a"}, 64'(jdo_a), 64'(data));
        chk({tag, "_jdo_early_b"}, 64'(jdo_b), 64'(data));
      end
      if (k == S + 2 && ack_pulse) ch_ack = oh;
      if (k == S + 3) ch_ack = '0;
    end
    vs_udr  = 1'b0;
    vs_uir  = 1'b0;
    exp_jdo = data;
    for (int d = 0; d < 2; d++) begin
      if (int'(cur_ir) < nch[d]) begin
        if (exp_pend[d][cur_ir] && !ack_pulse) begin
          exp_ovr[d] = 1'b1;
`ifdef DBG_SLAVE_OVR_CNT_EN
          if (exp_cnt[d] < 255) exp_cnt[d]++;
`endif
        end
        exp_pend[d][cur_ir] = 1'b1;
      end else begin
        exp_bad[d] = 1'b1;
      end
    end
    repeat (S + 2) @(negedge clk);
    check_model(tag);
  endtask

  task automatic ack_only(input logic [IR_W-1:0] ch);
    @(negedge clk);
    ch_ack = 4'b0001 << ch;
    @(negedge clk);
    ch_ack = '0;
    for (int d = 0; d < 2; d++) if (int'(ch) < nch[d]) exp_pend[d][ch] = 1'b0;
    @(negedge clk);
    check_model("ack");
  endtask

  task automatic clear_errors();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_ovr[d] = 1'b0;
      exp_bad[d] = 1'b0;
      exp_cnt[d] = 0;
    end
    check_model("clr");
  endtask

  initial begin
    logic [DR_W-1:0] d;
    int op;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("por");
    reset_n = 1'b1;
    repeat (S + 4) @(negedge clk);

    // basic action / no-action on channel 2
    set_ir(2'd2);
    send("act2", 38'h20_0000_0055, 1'b0, '0, 1'b0);
    ack_only(2'd2);
    send("noact2", 38'h00_0000_0055, 1'b0, '0, 1'b0);
    ack_only(2'd2);

    // overrun on channel 1, then clear
    set_ir(2'd1);
    send("ovr1a", 38'h20_1234_5678, 1'b0, '0, 1'b0);
    send("ovr1b", 38'h01_0000_00AA, 1'b0, '0, 1'b0);
    clear_errors();
    ack_only(2'd1);

    // same-cycle ack on a pending channel 0: no overrun
    set_ir(2'd0);
    send("sc0a", 38'h3F_FFFF_FFFF, 1'b0, '0, 1'b0);
    send("sc0b", 38'h15_5555_5555, 1'b0, '0, 1'b1);

    // unmapped instruction on the 3-channel instance, via simultaneous IR+DR
    send("ir3", 38'h2A_AAAA_AAAA, 1'b1, 2'd3, 1'b0);
    clear_errors();

    // randomized operations
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 9);
      d  = {6'($urandom), 32'($urandom)};
      if (op <= 5)      send("rnd", d, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                             ($urandom_range(0, 3) == 0));
      else if (op <= 7) ack_only(2'($urandom_range(0, 3)));
      else if (op == 8) clear_errors();
      else              set_ir(2'($urandom_range(0, 3)));
    end

    // reset while channel 3 pending and vs_udr high
    set_ir(2'd3);
    send("pre_rst", 38'h20_0000_0003, 1'b0, '0, 1'b0);
    @(negedge clk);
    sr     = 38'h20_0000_0077;
    vs_udr = 1'b1;
    repeat (2) @(negedge clk);
    do_reset("midrst");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("hold_high_pulse_a", 64'({ta_a, tn_a, pend_a}), 64'd0);
      chk("hold_high_pulse_b", 64'({ta_b, tn_b, pend_b}), 64'd0);
    end
    vs_udr = 1'b0;
    repeat (S + 3) @(negedge clk);
    send("post_rst", 38'h20_0000_00C3, 1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
